// File: rtl/huff_bit_decoder.sv
// -----------------------------------------------------------------------------
// huff_bit_decoder
//
// Huffman decoder. It takes an MSB-first serial bitstream and emits symbol
// indices. The code table holds up to NSYM entries. The host loads the table
// while the decoder is in IDLE. Decoding starts with dec_start and runs at up
// to one bit per cycle. Each accepted bit extends the current candidate code,
// and that candidate is compared against every table entry. When an entry
// matches, the decoder issues a one-cycle sym_valid pulse. If MAX_LEN bits
// arrive without any match, the decoder enters the sticky error state.
//
// Optional feature: when `HUFF_DEC_CNT_EN is defined, sym_count counts the
// decoded symbols. The count wraps at 16 bits and is cleared by RST and by
// dec_start. When the macro is undefined, sym_count is tied to zero.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   tbl_we     in   table write strobe (IDLE only)
//   tbl_addr   in   table entry index
//   tbl_sym    in   symbol index for the entry
//   tbl_code   in   code, right-aligned, MSB transmitted first
//   tbl_len    in   code length 1..MAX_LEN, 0 marks the entry invalid
//   dec_start  in   IDLE/ERR -> DECODE, clears partial code and error
//   dec_stop   in   DECODE -> IDLE, drops any partial code
//   bit_in     in   serial data bit
//   bit_valid  in   bit_in qualifier
//   bit_ready  out  decoder accepts bits (DECODE state)
//   sym_out    out  last decoded symbol, held until the next one
//   sym_valid  out  one-cycle pulse per decoded symbol
//   dec_err    out  sticky: no code matched within MAX_LEN bits
//   busy       out  decoder is in DECODE
//   sym_count  out  decoded-symbol count (optional feature)
// -----------------------------------------------------------------------------
module huff_bit_decoder #(
  parameter int NSYM    = 8,
  parameter int MAX_LEN = 7,
  parameter int SYM_W   = 5
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         tbl_we,
  input  logic [$clog2(NSYM)-1:0]      tbl_addr,
  input  logic [SYM_W-1:0]             tbl_sym,
  input  logic [MAX_LEN-1:0]           tbl_code,
  input  logic [$clog2(MAX_LEN+1)-1:0] tbl_len,
  input  logic                         dec_start,
  input  logic                         dec_stop,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  output logic                         bit_ready,
  output logic [SYM_W-1:0]             sym_out,
  output logic                         sym_valid,
  output logic                         dec_err,
  output logic                         busy,
  output logic [15:0]                  sym_count
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] MAX_N = LW'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ERR} state_t;

  state_t             state;
  logic [SYM_W-1:0]   sym_tbl  [NSYM];
  logic [MAX_LEN-1:0] code_tbl [NSYM];
  logic [LW-1:0]      len_tbl  [NSYM];

  // acc holds the nbits bits received so far, right-aligned.
  logic [MAX_LEN-2:0] acc;
  logic [LW-1:0]      nbits;

  logic [LW-1:0]      n;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic               hit;
  logic [SYM_W-1:0]   hit_sym;
  logic               start_fire;
  logic               xfer;
  logic               sym_fire;

  assign n    = nbits + LW'(1);
  assign cand = {acc, bit_in};
  // Low n bits set. For n == MAX_LEN the shift clears every bit, so the mask is all ones.
  assign mask = ~({MAX_LEN{1'b1}} << n);

  assign start_fire = dec_start && (state == S_IDLE || state == S_ERR);
  // dec_stop wins over a bit in the same cycle, and that bit is not consumed.
  assign xfer       = (state == S_DECODE) && bit_valid && !dec_stop;
  assign sym_fire   = xfer && hit;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    hit     = 1'b0;
    hit_sym = '0;
    // Scan in ascending index order so the lowest matching index wins.
    for (int i = 0; i < NSYM; i++) begin
      if (!hit && len_tbl[i] == n && (code_tbl[i] & mask) == (cand & mask)) begin
        hit     = 1'b1;
        hit_sym = sym_tbl[i];
      end
    end
  end

  // NOTE: sym_tbl/code_tbl are not reset. len == 0 already marks an entry invalid,
  // so only the length field has to be cleared.
  always_ff @(posedge CLK) begin
    if (tbl_we && state == S_IDLE) begin
      sym_tbl[tbl_addr]  <= tbl_sym;
      code_tbl[tbl_addr] <= tbl_code;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      acc       <= '0;
      nbits     <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      for (int i = 0; i < NSYM; i++) len_tbl[i] <= '0;
    end else begin
      sym_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tbl_we) len_tbl[tbl_addr] <= tbl_len;
          if (start_fire) begin
            state <= S_DECODE;
            acc   <= '0;
            nbits <= '0;
          end
        end
        S_DECODE: begin
          if (dec_stop) begin
            state <= S_IDLE;
            acc   <= '0;
            nbits <= '0;
          end else if (xfer) begin
            if (hit) begin
              sym_out   <= hit_sym;
              sym_valid <= 1'b1;
              acc       <= '0;
              nbits     <= '0;
            end else if (n == MAX_N) begin
              state <= S_ERR;
              acc   <= '0;
              nbits <= '0;
            end else begin
              acc   <= cand[MAX_LEN-2:0];
              nbits <= n;
            end
          end
        end
        S_ERR: begin
          if (start_fire) begin
            state <= S_DECODE;
            acc   <= '0;
            nbits <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // These outputs decode the state flop directly, so they change only on the clock edge.
  assign bit_ready = (state == S_DECODE);
  assign busy      = (state == S_DECODE);
  assign dec_err   = (state == S_ERR);

`ifdef HUFF_DEC_CNT_EN
  logic [15:0] cnt_q;

  // The counter steps on the same edge that raises sym_valid.
  always_ff @(posedge CLK) begin
    if (RST || start_fire) cnt_q <= '0;
    else if (sym_fire)     cnt_q <= cnt_q + 16'd1;
  end

  assign sym_count = cnt_q;
`else
  assign sym_count = '0;
`endif

endmodule

// File: doc/huff_bit_decoder.md
Name: huff_bit_decoder

Overview:
- Decoding end of the Huffman path: consumes an MSB-first serial bitstream and emits 5-bit symbol indices.
- Uses a code table of up to 8 entries. The table is loaded by the host after the sort/tree stage has assigned codes.
- Sits between the bitstream source (FIFO/UART side) and the symbol sink.
- Single clock domain; table load and decode are mutually exclusive phases.

Parameters:
NSYM, 8, number of table entries (tbl_addr width = clog2(NSYM))
MAX_LEN, 7, maximum code length in bits
SYM_W, 5, symbol index width (matches node[4:0] field)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous, active-high reset
tbl_we  in  1  table write strobe (honoured in IDLE only)
tbl_addr  in  3  entry index
tbl_sym  in  SYM_W  symbol for entry
tbl_code  in  MAX_LEN  code, right-aligned, MSB transmitted first
tbl_len  in  3  code length 1..MAX_LEN; 0 = entry invalid
dec_start  in  1  IDLE/ERR -> DECODE
dec_stop  in  1  DECODE -> IDLE, discards partial code
bit_in  in  1  serial data bit
bit_valid  in  1  bit_in qualifier
bit_ready  out  1  high in DECODE only
sym_out  out  SYM_W  decoded symbol, held until next symbol
sym_valid  out  1  one-cycle pulse per decoded symbol
dec_err  out  1  sticky: no match within MAX_LEN bits
busy  out  1  high in DECODE
sym_count  out  16  decoded-symbol count (see Optional Feature)

Behaviour:
- Reset (RST=1 at a rising edge):
  - State = IDLE.
  - All table len fields = 0; sym/code table contents are don't-care.
  - acc = 0, nbits = 0.
  - Outputs: sym_out=0, sym_valid=0, dec_err=0, bit_ready=0, busy=0, sym_count=0.
  - Reset mid-decode aborts immediately; no symbol is emitted.
- States IDLE, DECODE, ERR:
  - IDLE: tbl_we writes entry tbl_addr. dec_start -> DECODE with acc=0, nbits=0.
  - DECODE: tbl_we ignored. dec_stop -> IDLE; dec_stop has priority over a bit in the same cycle, and that bit is not consumed.
  - ERR: bit_ready=0, dec_err=1. dec_start -> DECODE and clears dec_err, acc and nbits. tbl_we ignored.
- Bit transfer occurs on bit_valid & bit_ready.
- Candidate evaluation, on each transfer:
  - n = nbits+1; cand = {acc, bit_in} (low n bits).
  - Entry i matches when len_i == n and code_i[n-1:0] == cand[n-1:0].
  - If several entries match, the lowest index wins.
- On a match (registered, latency 1 cycle after the accepting edge):
  - sym_out = entry sym; sym_valid=1 for exactly one cycle.
  - acc=0, nbits=0.
  - A bit may be accepted in the same cycle that sym_valid is high, so back-to-back decode runs at 1 bit/cycle.
- No match, n < MAX_LEN: acc = cand, nbits = n.
- No match, n == MAX_LEN: -> ERR, dec_err=1 next cycle, sym_valid stays 0.
- Table with zero valid entries: every stream ends in ERR after MAX_LEN bits.
- No output backpressure: the sink must accept each sym_valid pulse.
- The table is loaded by the host: prefix-free codes and no duplicate length/code pairs.

Optional Feature:
- Macro HUFF_DEC_CNT_EN.
- Defined:
  - sym_count increments on every sym_valid.
  - Wraps 16'hFFFF -> 0.
  - Cleared by RST and by dec_start; not cleared by dec_stop.
- Undefined: sym_count tied to 0, counter logic absent.

Test Plan:
- Load idx0 {sym=1,code=0,len=1}, idx1 {2,10b,2}, idx2 {3,110b,3}, idx3 {4,111b,3}; dec_start; stream 0,1,0,1,1,0,1,1,1 at 1 bit/cycle -> sym_valid pulses with sym_out 1,2,3,4, each 1 cycle after bits 1,3,6,9; sym_count=4 with HUFF_DEC_CNT_EN.
- Table only idx0 {1,0,1}; stream seven 1s -> dec_err=1 the cycle after the 7th bit, bit_ready=0, no sym_valid; dec_start -> dec_err=0, stream 0 -> sym_out=1.
- Same four-entry table; bit_valid toggled 1/0 over stream 1,1,0 -> single sym_valid, sym_out=3, 1 cycle after third accepted bit.
- Decode after bits 1,1 (partial); assert dec_stop together with bit_valid=1, bit=0 -> IDLE, bit_ready=0, no sym_valid; tbl_we now accepted; dec_start then 0 -> sym_out=1.
- Assert RST after two bits of 110 -> all outputs 0 next cycle, len table cleared, dec_start then seven 0s -> dec_err=1.
- tbl_we asserted in DECODE overwriting idx0 with {sym=9} -> ignored; stream 0 still yields sym_out=1.
